// File: rtl/btb_read_unit.sv
`timescale 1ns/1ps
// btb_read_unit
// Read-side lookup for the 2-way set-associative branch target buffer.
// The tag compare and hit selection are combinational so fetch sees the
// prediction in the same cycle. Registered copies of the result and
// saturating lookup/hit counters feed the fetch pipeline and the
// performance monitors.
//
// Entry layout inside each 64-bit way:
//   [63]    valid
//   [62:36] tag
//   [35:4]  target
//   [3:2]   2-bit saturating-counter state (bit 3 = taken)
//   [1:0]   reserved
module btb_read_unit (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [127:0] read_set,
  input  logic [7:0]   LRU,
  input  logic [26:0]  read_tag,
  input  logic [2:0]   read_index,
  input  logic         lookup_en,
  output logic         next_LRU_read,
  output logic         valid,
  output logic         predictedTaken,
  output logic [31:0]  target,
  output logic         valid_q,
  output logic         predictedTaken_q,
  output logic         next_LRU_q,
  output logic [31:0]  target_q,
  output logic [15:0]  lookup_cnt,
  output logic [15:0]  hit_cnt
);

  localparam logic [15:0] CNT_MAX = 16'hFFFF;

  // Unpacked view of one way, so the select logic reads in field names.
  typedef struct packed {
    logic        vld;
    logic [26:0] tag;
    logic [31:0] tgt;
    logic [1:0]  state;
    logic [1:0]  rsvd;
  } btb_entry_t;

  btb_entry_t way1_entry;
  btb_entry_t way2_entry;
  logic       way1_hit;
  logic       way2_hit;

  // Reserved bits are carried in the entry but never consulted.
  logic       unused_rsvd;

  assign way1_entry  = btb_entry_t'(read_set[127:64]);
  assign way2_entry  = btb_entry_t'(read_set[63:0]);
  assign unused_rsvd = ^{way1_entry.rsvd, way2_entry.rsvd};

  // Per-way hit detection: an invalid entry never hits, whatever its tag.
  always_comb begin
    way1_hit = way1_entry.vld && (way1_entry.tag == read_tag);
    way2_hit = way2_entry.vld && (way2_entry.tag == read_tag);
  end

  // Hit select with way1 priority; the hit way becomes most recently used
  // (LRU bit points at the other way), a miss leaves the set's LRU bit alone.
  always_comb begin
    valid          = 1'b0;
    predictedTaken = 1'b0;
    target         = 32'h0;
    next_LRU_read  = LRU[read_index];
    if (way1_hit) begin
      valid          = 1'b1;
      predictedTaken = way1_entry.state[1];
      target         = way1_entry.tgt;
      next_LRU_read  = 1'b0;
    end else if (way2_hit) begin
      valid          = 1'b1;
      predictedTaken = way2_entry.state[1];
      target         = way2_entry.tgt;
      next_LRU_read  = 1'b1;
    end
  end

  logic        valid_d;
  logic        predictedTaken_d;
  logic        next_LRU_d;
  logic [31:0] target_d;
  logic [15:0] lookup_cnt_d;
  logic [15:0] hit_cnt_d;
  logic [15:0] lookup_cnt_q;
  logic [15:0] hit_cnt_q;

  // Next-state for the captured result and the saturating counters;
  // everything holds when the lookup is not qualified.
  always_comb begin
    valid_d          = valid_q;
    predictedTaken_d = predictedTaken_q;
    next_LRU_d       = next_LRU_q;
    target_d         = target_q;
    lookup_cnt_d     = lookup_cnt_q;
    hit_cnt_d        = hit_cnt_q;
    if (lookup_en) begin
      valid_d          = valid;
      predictedTaken_d = predictedTaken;
      next_LRU_d       = next_LRU_read;
      target_d         = target;
      if (lookup_cnt_q != CNT_MAX) begin
        lookup_cnt_d = lookup_cnt_q + 16'd1;
      end
      if (valid && (hit_cnt_q != CNT_MAX)) begin
        hit_cnt_d = hit_cnt_q + 16'd1;
      end
    end
  end

  // State registers, cleared asynchronously while rst_n is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q          <= 1'b0;
      predictedTaken_q <= 1'b0;
      next_LRU_q       <= 1'b0;
      target_q         <= 32'h0;
      lookup_cnt_q     <= 16'h0;
      hit_cnt_q        <= 16'h0;
    end else begin
      valid_q          <= valid_d;
      predictedTaken_q <= predictedTaken_d;
      next_LRU_q       <= next_LRU_d;
      target_q         <= target_d;
      lookup_cnt_q     <= lookup_cnt_d;
      hit_cnt_q        <= hit_cnt_d;
    end
  end

  assign lookup_cnt = lookup_cnt_q;
  assign hit_cnt    = hit_cnt_q;

endmodule

// File: tb/tb_btb_read_unit.sv
`timescale 1ns/1ps
// tb_btb_read_unit
// Directed vectors with hand-computed expectations for the BTB read unit:
// combinational lookups first, then a clocked run covering reset, capture,
// hold, asynchronous mid-run reset and counter saturation.
module tb_btb_read_unit;

  logic         clk;
  logic         rst_n;
  logic [127:0] read_set;
  logic [7:0]   LRU;
  logic [26:0]  read_tag;
  logic [2:0]   read_index;
  logic         lookup_en;
  logic         next_LRU_read;
  logic         valid;
  logic         predictedTaken;
  logic [31:0]  target;
  logic         valid_q;
  logic         predictedTaken_q;
  logic         next_LRU_q;
  logic [31:0]  target_q;
  logic [15:0]  lookup_cnt;
  logic [15:0]  hit_cnt;

  int checkCount = 0;
  int failCount  = 0;

  btb_read_unit dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .read_set         (read_set),
    .LRU              (LRU),
    .read_tag         (read_tag),
    .read_index       (read_index),
    .lookup_en        (lookup_en),
    .next_LRU_read    (next_LRU_read),
    .valid            (valid),
    .predictedTaken   (predictedTaken),
    .target           (target),
    .valid_q          (valid_q),
    .predictedTaken_q (predictedTaken_q),
    .next_LRU_q       (next_LRU_q),
    .target_q         (target_q),
    .lookup_cnt       (lookup_cnt),
    .hit_cnt          (hit_cnt)
  );

  // Free-running 100 MHz clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case anything stalls.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [63:0] makeEntry(input logic v, input logic [26:0] tag,
                                            input logic [31:0] tgt, input logic [1:0] st,
                                            input logic [1:0] rsvd);
    return {v, tag, tgt, st, rsvd};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: actual=%h required=%h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [63:0] way1, input logic [63:0] way2,
                               input logic [7:0] lru, input logic [26:0] tag,
                               input logic [2:0] idx, input logic en);
    read_set   = {way1, way2};
    LRU        = lru;
    read_tag   = tag;
    read_index = idx;
    lookup_en  = en;
    #1;
  endtask

  task automatic checkComb(input string tag, input logic expValid, input logic expTaken,
                           input logic [31:0] expTarget, input logic expLru);
    checkOutput({tag, ".valid"},  32'(valid),          32'(expValid));
    checkOutput({tag, ".taken"},  32'(predictedTaken), 32'(expTaken));
    checkOutput({tag, ".target"}, target,              expTarget);
    checkOutput({tag, ".lru"},    32'(next_LRU_read),  32'(expLru));
  endtask

  task automatic checkRegs(input string tag, input logic expValid, input logic expTaken,
                           input logic [31:0] expTarget, input logic expLru,
                           input logic [15:0] expLookups, input logic [15:0] expHits);
    checkOutput({tag, ".valid_q"},  32'(valid_q),          32'(expValid));
    checkOutput({tag, ".taken_q"},  32'(predictedTaken_q), 32'(expTaken));
    checkOutput({tag, ".target_q"}, target_q,              expTarget);
    checkOutput({tag, ".lru_q"},    32'(next_LRU_q),       32'(expLru));
    checkOutput({tag, ".lookups"},  32'(lookup_cnt),       32'(expLookups));
    checkOutput({tag, ".hits"},     32'(hit_cnt),          32'(expHits));
  endtask

  logic [63:0] hitA;
  logic [63:0] hitB;
  logic [63:0] deadA;

  initial begin
    rst_n = 1'b0;
    hitA  = makeEntry(1'b1, 27'h1A5, 32'hCAFEBABE, 2'b10, 2'b00);
    hitB  = makeEntry(1'b1, 27'h2B7, 32'h12345678, 2'b11, 2'b11);
    deadA = makeEntry(1'b0, 27'h3C3, 32'hDEADBEEF, 2'b11, 2'b00);

    // Combinational lookups.
    applyStimulus(64'h0, 64'h0, 8'h00, 27'h0, 3'd2, 1'b0);
    checkComb("zero", 1'b0, 1'b0, 32'h0, 1'b0);

    applyStimulus(hitA, 64'h0, 8'h01, 27'h1A5, 3'd0, 1'b0);
    checkComb("way1", 1'b1, 1'b1, 32'hCAFEBABE, 1'b0);

    applyStimulus(64'h0, hitB, 8'hFE, 27'h2B7, 3'd1, 1'b0);
    checkComb("way2", 1'b1, 1'b1, 32'h12345678, 1'b1);

    applyStimulus(makeEntry(1'b1, 27'h0AA, 32'hAAAAAAAA, 2'b01, 2'b00),
                  makeEntry(1'b1, 27'h0AA, 32'hBBBBBBBB, 2'b10, 2'b00),
                  8'h00, 27'h0AA, 3'd5, 1'b0);
    checkComb("both", 1'b1, 1'b0, 32'hAAAAAAAA, 1'b0);

    applyStimulus(deadA, 64'h0, 8'h08, 27'h3C3, 3'd3, 1'b0);
    checkComb("invalid", 1'b0, 1'b0, 32'h0, 1'b1);

    applyStimulus(deadA, makeEntry(1'b1, 27'h3C3, 32'h0BADF00D, 2'b01, 2'b00),
                  8'h00, 27'h3C3, 3'd4, 1'b0);
    checkComb("inv1hit2", 1'b1, 1'b0, 32'h0BADF00D, 1'b1);

    applyStimulus(hitA, hitB, 8'h80, 27'h1A5 | 27'h4000000, 3'd7, 1'b0);
    checkComb("tagmsb", 1'b0, 1'b0, 32'h0, 1'b1);

    // Clocked run: reset state while the clock is toggling.
    @(negedge clk);
    applyStimulus(hitA, 64'h0, 8'h01, 27'h1A5, 3'd0, 1'b1);
    @(posedge clk); #1;
    checkRegs("reset", 1'b0, 1'b0, 32'h0, 1'b0, 16'd0, 16'd0);

    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    checkRegs("lk1", 1'b1, 1'b1, 32'hCAFEBABE, 1'b0, 16'd1, 16'd1);

    @(negedge clk);
    applyStimulus(64'h0, hitB, 8'hFE, 27'h2B7, 3'd1, 1'b1);
    @(posedge clk); #1;
    checkRegs("lk2", 1'b1, 1'b1, 32'h12345678, 1'b1, 16'd2, 16'd2);

    @(negedge clk);
    applyStimulus(deadA, 64'h0, 8'h08, 27'h3C3, 3'd3, 1'b1);
    @(posedge clk); #1;
    checkRegs("lk3", 1'b0, 1'b0, 32'h0, 1'b1, 16'd3, 16'd2);

    @(negedge clk);
    applyStimulus(hitA, 64'h0, 8'h00, 27'h1A5, 3'd0, 1'b0);
    @(posedge clk); #1;
    checkRegs("hold", 1'b0, 1'b0, 32'h0, 1'b1, 16'd3, 16'd2);

    // Asynchronous reset between edges; combinational path keeps tracking.
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checkRegs("asyncrst", 1'b0, 1'b0, 32'h0, 1'b0, 16'd0, 16'd0);
    checkComb("combinrst", 1'b1, 1'b1, 32'hCAFEBABE, 1'b0);

    // Saturation: run enabled hits past the counter range.
    @(negedge clk);
    applyStimulus(hitA, 64'h0, 8'h00, 27'h1A5, 3'd0, 1'b1);
    rst_n = 1'b1;
    repeat (65534) @(posedge clk);
    #1;
    checkOutput("prelookups", 32'(lookup_cnt), 32'h0000FFFE);
    checkOutput("prehits",    32'(hit_cnt),    32'h0000FFFE);
    repeat (5) @(posedge clk);
    #1;
    checkOutput("satlookups", 32'(lookup_cnt), 32'h0000FFFF);
    checkOutput("sathits",    32'(hit_cnt),    32'h0000FFFF);
    checkOutput("satvalid",   32'(valid_q),    32'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule
